// File: rtl/gpu_defs.sv
// gpu_defs: shared display geometry defaults, pixel-entry field widths and scheduler states
package gpu_defs;

    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int COLOR_W_DEF = 12;
    localparam int ADDR_W_DEF  = 19;
    localparam int COORD_W     = 10;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO with flush, accepting a push while full when a pop happens in the same cycle
module pixel_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (flush || !full || do_pop);
    assign dout    = mem[rd_ptr];

    // flush empties the queue, yet a push in the same cycle still lands as the sole entry
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? (AW+1)'(1) : '0;
        end else begin
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            count  <= count + (do_push ? (AW+1)'(1) : '0) - (do_pop ? (AW+1)'(1) : '0);
        end
    end

    // storage write; after a flush the new entry goes to slot 0
    always_ff @(posedge clk) begin
        if (do_push) mem[flush ? '0 : wr_ptr] <= din;
    end

endmodule

// File: rtl/pixel_write_scheduler.sv
// pixel_write_scheduler: queues pixel writes and full-frame fills, issuing framebuffer writes only on blanking grants
module pixel_write_scheduler
    import gpu_defs::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int COLOR_W    = COLOR_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_set_pixel,
    input  logic [9:0]         i_pixel_x,
    input  logic [9:0]         i_pixel_y,
    input  logic [COLOR_W-1:0] i_color,
    input  logic               i_fill,
    input  logic               i_blank,
    output logic               o_fb_we,
    output logic [ADDR_W-1:0]  o_fb_addr,
    output logic [COLOR_W-1:0] o_fb_data,
    output logic               o_busy,
    output logic               o_overflow
);
    localparam int ENTRY_W = 2*COORD_W + COLOR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES*V_RES - 1);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  fill_cnt, pix_addr, addr_nxt;
    logic [COLOR_W-1:0] fill_color, data_nxt, hcolor;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   count;
    logic [COORD_W-1:0] hx, hy;
    logic               full, empty, pop, push_ok, in_range, we_nxt, busy_nxt;

    assign {hx, hy, hcolor} = head;

    pixel_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_clk),
        .reset (i_reset),
        .push  (i_set_pixel),
        .pop   (pop),
        .flush (i_fill),
        .din   ({i_pixel_x, i_pixel_y, i_color}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    if (H_RES == 640) begin : g_shift
        assign pix_addr = (ADDR_W'(hy) << 9) + (ADDR_W'(hy) << 7) + ADDR_W'(hx);
    end else begin : g_mul
        assign pix_addr = ADDR_W'(hy) * ADDR_W'(H_RES) + ADDR_W'(hx);
    end

    assign in_range = (32'(hx) < H_RES) && (32'(hy) < V_RES);
    assign pop      = (state == IDLE) && !empty && i_blank && !i_fill;
    assign push_ok  = i_set_pixel && (i_fill || !full || pop);

    // next state and next values of the registered write port; a fill request preempts any write this cycle
    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        addr_nxt  = '0;
        data_nxt  = '0;
        if (i_fill) begin
            state_nxt = FILL;
        end else if (state == FILL && i_blank) begin
            we_nxt    = 1'b1;
            addr_nxt  = fill_cnt;
            data_nxt  = fill_color;
            state_nxt = (fill_cnt == LAST) ? IDLE : FILL;
        end else if (pop && in_range) begin
            we_nxt   = 1'b1;
            addr_nxt = pix_addr;
            data_nxt = hcolor;
        end
        busy_nxt = (state_nxt == FILL) || push_ok || (count > CNT_W'(pop));
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // fill sequencing plus registered framebuffer port, busy and sticky overflow
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fill_cnt   <= '0;
            fill_color <= '0;
            o_fb_we    <= 1'b0;
            o_fb_addr  <= '0;
            o_fb_data  <= '0;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (i_fill) begin
                fill_cnt   <= '0;
                fill_color <= i_color;
            end else if (state == FILL && i_blank) begin
                fill_cnt <= (fill_cnt == LAST) ? '0 : fill_cnt + ADDR_W'(1);
            end
            o_fb_we    <= we_nxt;
            o_fb_addr  <= addr_nxt;
            o_fb_data  <= data_nxt;
            o_busy     <= busy_nxt;
            o_overflow <= o_overflow || (i_set_pixel && !push_ok);
        end
    end

endmodule

// File: tb/tb_pixel_write_scheduler.sv
// tb_pixel_write_scheduler: directed checks of queueing, grants, overflow, fill sequencing and reset
module tb_pixel_write_scheduler;
    logic        clk = 1'b0;
    logic        reset, set_pixel, fill, blank;
    logic [9:0]  px, py;
    logic [11:0] color;
    logic        fb_we, busy, overflow;
    logic [18:0] fb_addr;
    logic [11:0] fb_data;
    int          errors = 0;
    int          checks = 0;

    pixel_write_scheduler #(
        .H_RES(8), .V_RES(4), .ADDR_W(19), .COLOR_W(12), .FIFO_DEPTH(4)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_set_pixel (set_pixel),
        .i_pixel_x   (px),
        .i_pixel_y   (py),
        .i_color     (color),
        .i_fill      (fill),
        .i_blank     (blank),
        .o_fb_we     (fb_we),
        .o_fb_addr   (fb_addr),
        .o_fb_data   (fb_data),
        .o_busy      (busy),
        .o_overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [18:0] a, input logic [11:0] d);
        chk({tag, "_we"}, 32'(fb_we), 32'd1);
        chk({tag, "_addr"}, 32'(fb_addr), 32'(a));
        chk({tag, "_data"}, 32'(fb_data), 32'(d));
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [11:0] c);
        set_pixel = 1'b1;
        px = x;
        py = y;
        color = c;
    endtask

    initial begin
        reset = 1'b1; set_pixel = 1'b0; fill = 1'b0; blank = 1'b0;
        px = '0; py = '0; color = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_we", 32'(fb_we), 0);
        chk("rst_addr", 32'(fb_addr), 0);
        chk("rst_data", 32'(fb_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // isolated pixel, grant held high
        blank = 1'b1;
        pix(3, 2, 12'hF00);
        tick();
        set_pixel = 1'b0;
        chk("lat_we0", 32'(fb_we), 0);
        chk("lat_busy_hi", 32'(busy), 1);
        tick();
        chk_wr("lat_wr", 19'd19, 12'hF00);
        chk("lat_busy_lo", 32'(busy), 0);
        tick();
        chk("lat_we_one_cycle", 32'(fb_we), 0);

        // five pushes without grant: fifth dropped
        blank = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pix(10'(i), 0, 12'(i + 1));
            tick();
            chk("ovf_nowrite", 32'(fb_we), 0);
            if (i == 3) chk("ovf_not_yet", 32'(overflow), 0);
        end
        set_pixel = 1'b0;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_busy", 32'(busy), 1);
        blank = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_wr("drain", 19'(i), 12'(i + 1));
            chk("drain_busy", 32'(busy), (i == 3) ? 0 : 1);
        end
        tick();
        chk("drain_no5th", 32'(fb_we), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // out-of-range entry consumes a grant without writing
        pix(8, 0, 12'h005);
        tick();
        pix(1, 1, 12'h006);
        tick();
        set_pixel = 1'b0;
        chk("oor_nowrite", 32'(fb_we), 0);
        tick();
        chk_wr("oor_next", 19'd9, 12'h006);
        tick();
        chk("oor_idle_we", 32'(fb_we), 0);
        chk("oor_idle_busy", 32'(busy), 0);

        // fill with grant toggling
        blank = 1'b0;
        fill = 1'b1;
        color = 12'h0A5;
        tick();
        fill = 1'b0;
        chk("fill_start_busy", 32'(busy), 1);
        chk("fill_start_we", 32'(fb_we), 0);
        for (int k = 0; k < 32; k++) begin
            blank = 1'b1;
            tick();
            chk_wr("fill", 19'(k), 12'h0A5);
            chk("fill_busy", 32'(busy), (k == 31) ? 0 : 1);
            blank = 1'b0;
            tick();
            chk("fill_gap_we", 32'(fb_we), 0);
        end
        chk("fill_done_busy", 32'(busy), 0);

        // queued pixels flushed by a fill; simultaneous pixel lands afterwards
        pix(2, 0, 12'h111);
        tick();
        pix(3, 0, 12'h222);
        tick();
        pix(0, 0, 12'h0C3);
        fill = 1'b1;
        blank = 1'b1;
        tick();
        fill = 1'b0;
        set_pixel = 1'b0;
        chk("flush_no_wr", 32'(fb_we), 0);
        for (int k = 0; k < 32; k++) begin
            tick();
            chk_wr("flush_fill", 19'(k), 12'h0C3);
            chk("flush_busy", 32'(busy), 1);
        end
        tick();
        chk_wr("flush_pix", 19'd0, 12'h0C3);
        chk("flush_busy_lo", 32'(busy), 0);
        tick();
        chk("flush_end_we", 32'(fb_we), 0);

        // reset mid-fill, with a coincident set_pixel that must be ignored
        fill = 1'b1;
        color = 12'h777;
        tick();
        fill = 1'b0;
        for (int k = 0; k <= 10; k++) tick();
        chk_wr("mid_fill", 19'd10, 12'h777);
        chk("mid_ovf", 32'(overflow), 1);
        reset = 1'b1;
        pix(1, 0, 12'h333);
        tick();
        reset = 1'b0;
        set_pixel = 1'b0;
        chk("mrst_we", 32'(fb_we), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_ovf", 32'(overflow), 0);
        tick();
        chk("mrst_idle_we", 32'(fb_we), 0);
        chk("mrst_idle_busy", 32'(busy), 0);
        pix(2, 3, 12'hABC);
        tick();
        set_pixel = 1'b0;
        tick();
        chk_wr("post_rst", 19'd26, 12'hABC);
        tick();
        chk("post_rst_we", 32'(fb_we), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pixel_write_scheduler.md
Name: pixel_write_scheduler

Overview:
- Sits between instruction_decoder and the framebuffer RAM write port.
- Accepts single-cycle pixel-write pulses (set_pixel, x, y, color) and full-screen fill requests.
- Queues requests and issues framebuffer writes only in cycles the signal generator grants (blanking).
- Handles linear address generation, range checking, overflow reporting and fill sequencing.

Parameters:
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines per frame.
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- COLOR_W, 12, color width.
- FIFO_DEPTH, 4, pixel queue entries; power of two, >= 2.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_set_pixel  in  1  one-cycle pulse: enqueue {i_pixel_x, i_pixel_y, i_color}.
- i_pixel_x  in  10  pixel column.
- i_pixel_y  in  10  pixel row.
- i_color  in  COLOR_W  pixel or fill color.
- i_fill  in  1  one-cycle pulse: fill the whole frame with i_color.
- i_blank  in  1  write grant; high means the framebuffer port is free in the next cycle.
- o_fb_we  out  1  framebuffer write enable.
- o_fb_addr  out  ADDR_W  framebuffer write address.
- o_fb_data  out  COLOR_W  framebuffer write data.
- o_busy  out  1  queue non-empty or fill in progress.
- o_overflow  out  1  sticky: a pixel request was dropped because the queue was full.

Behaviour:
- Reset: all outputs 0; queue empty; state IDLE; fill counter 0. Reset mid-fill or mid-queue abandons all work immediately; o_fb_we is 0 in the cycle after reset.
- All outputs are registered.
- Grant rule: i_blank is sampled at edge N. A write (if any) appears on o_fb_* during cycle N+1 for exactly one cycle. At most one write per granted cycle. No write when i_blank=0.
- Queue: synchronous FIFO of {x, y, color}.
  - Push on i_set_pixel.
  - Pop when state=IDLE, queue non-empty and i_blank=1.
  - Push while full with a simultaneous pop: accepted.
  - Push while full with no pop: entry dropped, o_overflow set until reset.
- State machine:
  - IDLE: the head entry is popped on grant.
    - In range (x < H_RES and y < V_RES): write with addr = y*H_RES + x, computed at ADDR_W bits with no truncation for in-range inputs.
    - Out of range: entry popped silently, no write, and the grant slot is consumed.
  - IDLE -> FILL on i_fill:
    - Latch i_color as the fill color.
    - Flush the queue, since earlier pixels would be overwritten.
    - Clear the fill counter.
  - FILL: on each grant, write fill color at addr = counter, then counter++. After writing H_RES*V_RES-1, return to IDLE on the next edge.
  - i_fill while in FILL: restarts the fill (counter=0, new color latched, queue flushed).
  - i_set_pixel in FILL: enqueued normally; drained after the fill completes, so these pixels land on top of the fill.
- Simultaneous i_fill and i_set_pixel in the same cycle: flush first, then the new pixel is enqueued (queue holds 1 entry).
- Simultaneous i_set_pixel and i_reset: reset wins.
- o_busy = (queue count != 0) || (state == FILL), registered.
  - Rises the cycle after the first accepted request.
  - Falls the cycle after the last pop or the final fill write issue.
- Latency: an isolated pixel with i_blank held high appears on o_fb_we 2 cycles after the i_set_pixel pulse (1 cycle enqueue, 1 cycle issue).
- Fill duration: H_RES*V_RES granted cycles.

Decomposition:
- Shared include/package gpu_defs:
  - H_RES, V_RES, COLOR_W, ADDR_W defaults.
  - Pixel-entry field widths and packing: {x[9:0], y[9:0], color}.
  - State encodings IDLE and FILL.
  - Also used by instruction_decoder and the signal generator.
- One sub-module, pixel_fifo:
  - Parameterised synchronous FIFO (WIDTH, DEPTH) with push, pop, flush, full, empty and count.
  - Push-when-full-with-pop must be supported.
- Address multiply:
  - Stays in pixel_write_scheduler.
  - Constant multiply by H_RES; for 640 use shift-add ((y<<9)+(y<<7)+x).
  - Generic parameters fall back to the synthesis multiply.

Test Plan:
- (H_RES=8, V_RES=4) i_blank=1; set_pixel x=3, y=2, color=12'hF00 -> 2 cycles later o_fb_we=1, o_fb_addr=19, o_fb_data=12'hF00, for one cycle; o_busy high then low.
- i_blank=0; push 5 pixels (FIFO_DEPTH=4) -> o_overflow=1 sticky, no writes. Raise i_blank -> exactly 4 writes in order, the 5th pixel absent.
- set_pixel x=8, y=0 (out of range), then x=1, y=1 -> no write for the first; the second is written at addr 9 one granted cycle later.
- i_fill color=12'h0A5 with i_blank toggling 1,0,1,... -> 32 writes, addr 0..31 in order, only in cycles after i_blank=1. o_busy stays high throughout and drops after addr 31.
- Queue 2 pixels with i_blank=0, then i_fill with a set_pixel x=0, y=0 in the same cycle -> queued pixels never written; 32 fill writes, then a write at addr 0 with the pixel color.
- Assert i_reset mid-fill at addr 10 -> o_fb_we=0 next cycle, o_busy=0, o_overflow=0. A subsequent set_pixel works normally.
